// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6..0 = g..a),
// digit count and a pattern-to-BCD decode helper.
package seg7_pkg;

  localparam int NUM_DIG = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       hit;
    logic       is_blank;
    logic [3:0] value;
  } seg_dec_t;

  // hit=1 only for a numeral; all-off reports is_blank with hit=0.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t d;
    d = '0;
    case (seg)
      SEG_0:     begin d.hit = 1'b1; d.value = 4'd0; end
      SEG_1:     begin d.hit = 1'b1; d.value = 4'd1; end
      SEG_2:     begin d.hit = 1'b1; d.value = 4'd2; end
      SEG_3:     begin d.hit = 1'b1; d.value = 4'd3; end
      SEG_4:     begin d.hit = 1'b1; d.value = 4'd4; end
      SEG_5:     begin d.hit = 1'b1; d.value = 4'd5; end
      SEG_6:     begin d.hit = 1'b1; d.value = 4'd6; end
      SEG_7:     begin d.hit = 1'b1; d.value = 4'd7; end
      SEG_8:     begin d.hit = 1'b1; d.value = 4'd8; end
      SEG_9:     begin d.hit = 1'b1; d.value = 4'd9; end
      SEG_BLANK: d.is_blank = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern lookup around the shared decode function.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       is_blank,
  output logic [3:0] value
);

  seg_dec_t dec;

  always_comb dec = seg_decode(seg);

  assign hit      = dec.hit;
  assign is_blank = dec.is_blank;
  assign value    = dec.value;

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed active-low 4-digit 7-segment bus and rebuilds the
// displayed digits, filtering anode-switch ghosting and ageing out stale digits.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg,
  input  logic [NUM_DIG-1:0]   an,
  output logic [4*NUM_DIG-1:0] digits,
  output logic [NUM_DIG-1:0]   valid,
  output logic [NUM_DIG-1:0]   blank,
  output logic [NUM_DIG-1:0]   stale,
  output logic                 upd,
  output logic [1:0]           upd_idx,
  output logic                 seg_err,
  output logic                 an_err
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

  logic [6:0]         seg_m, seg_s, seg_p;
  logic [NUM_DIG-1:0] an_m, an_s, an_p;
  logic [RUN_W-1:0]   run, run_nxt;
  logic [AGE_W-1:0]   age     [NUM_DIG];
  logic [AGE_W-1:0]   age_nxt [NUM_DIG];

  logic               an_one;
  logic [1:0]         an_idx;
  logic               differs;
  logic               multi_low;
  logic               commit;
  logic [NUM_DIG-1:0] commit_dig;

  logic               dec_hit;
  logic               dec_blank;
  logic [3:0]         dec_value;

  // Synchronisers idle at all-ones so reset looks like a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      seg_s <= '1;
      an_m  <= '1;
      an_s  <= '1;
      seg_p <= '1;
      an_p  <= '1;
    end else begin
      seg_m <= seg;
      seg_s <= seg_m;
      an_m  <= an;
      an_s  <= an_m;
      seg_p <= seg_s;
      an_p  <= an_s;
    end
  end

  always_comb begin
    an_one = 1'b1;
    an_idx = '0;
    case (an_s)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_one = 1'b0;
    endcase
  end

  assign differs   = ({an_s, seg_s} != {an_p, seg_p});
  assign multi_low = !an_one && (an_s != '1);

  // A run that is already saturated and unchanged must not commit again.
  always_comb begin
    run_nxt = '0;
    commit  = 1'b0;
    if (an_one) begin
      if (differs) begin
        run_nxt = RUN_W'(1);
      end else if (run == RUN_MAX) begin
        run_nxt = RUN_MAX;
      end else begin
        run_nxt = run + 1'b1;
      end
      commit = (run_nxt == RUN_MAX) && (differs || (run != RUN_MAX));
    end
  end

  always_comb begin
    commit_dig = '0;
    if (commit) commit_dig[an_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) begin
      age_nxt[i] = age[i];
      if (commit_dig[i]) begin
        age_nxt[i] = '0;
      end else if (age[i] != AGE_MAX) begin
        age_nxt[i] = age[i] + 1'b1;
      end
    end
  end

  seg7_pattern_decode u_dec (
    .seg      (seg_s),
    .hit      (dec_hit),
    .is_blank (dec_blank),
    .value    (dec_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      seg_err <= 1'b0;
      an_err  <= 1'b0;
      digits  <= '0;
      valid   <= '0;
      blank   <= '0;
      stale   <= '0;
      for (int i = 0; i < NUM_DIG; i++) age[i] <= '0;
    end else begin
      run     <= run_nxt;
      upd     <= commit;
      upd_idx <= commit ? an_idx : 2'd0;
      seg_err <= commit && !dec_hit && !dec_blank;
      an_err  <= multi_low && differs;
      for (int i = 0; i < NUM_DIG; i++) begin
        age[i] <= age_nxt[i];
        // A commit in the same cycle as the timeout takes priority.
        if (commit_dig[i]) begin
          stale[i] <= 1'b0;
          valid[i] <= dec_hit;
          blank[i] <= dec_blank;
          if (dec_hit) digits[4*i +: 4] <= dec_value;
        end else if (age_nxt[i] == AGE_MAX) begin
          stale[i] <= 1'b1;
          valid[i] <= 1'b0;
          blank[i] <= 1'b0;
        end
      end
    end
  end

endmodule
